// File: rtl/row_stat_upd.sv
// Online-softmax row statistics: per-row running max / exp-sum over a TIL x TIL score tile,
// with an old/new snapshot handed to the coefficient unit between tiles.

module row_stat_lane #(
  parameter int D_W = 8,
  parameter int LW  = 2*D_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  acc,
  input  logic                  upd,
  input  logic signed [D_W-1:0] s,
  output logic [D_W-1:0]        m_run,
  output logic [D_W-1:0]        m_old,
  output logic [LW-1:0]         l_run,
  output logic [LW-1:0]         l_old
);
  localparam logic [D_W-1:0] M_MIN = {1'b1, {(D_W-1){1'b0}}};

  // exp(x/32) in Q1.7 for x in [-128,0]; split as e^(-a/4) * e^(-b/32), both Q1.8.
  function automatic logic [7:0] exp_q17(input logic signed [D_W:0] x);
    logic signed [D_W:0] nx;
    logic [7:0]  n;
    logic [8:0]  ea, eb;
    logic [17:0] p;
    nx = -x;
    n  = (x < -128) ? 8'd128 : nx[7:0];
    case (n[7:3])
      5'd0:  ea = 9'd256;  5'd1:  ea = 9'd199;  5'd2:  ea = 9'd155;
      5'd3:  ea = 9'd121;  5'd4:  ea = 9'd94;   5'd5:  ea = 9'd73;
      5'd6:  ea = 9'd57;   5'd7:  ea = 9'd44;   5'd8:  ea = 9'd35;
      5'd9:  ea = 9'd27;   5'd10: ea = 9'd21;   5'd11: ea = 9'd16;
      5'd12: ea = 9'd13;   5'd13: ea = 9'd10;   5'd14: ea = 9'd8;
      5'd15: ea = 9'd6;    default: ea = 9'd5;
    endcase
    case (n[2:0])
      3'd0: eb = 9'd256;  3'd1: eb = 9'd248;  3'd2: eb = 9'd240;
      3'd3: eb = 9'd233;  3'd4: eb = 9'd226;  3'd5: eb = 9'd219;
      3'd6: eb = 9'd212;  default: eb = 9'd206;
    endcase
    p = 18'(ea) * 18'(eb) + 18'd256;
    return p[16:9];
  endfunction

  logic signed [D_W-1:0] m_s, m_nx;
  logic signed [D_W:0]   d_run, d_s;
  logic [7:0]            e_run, e_s;
  logic [LW+7:0]         prod;
  logic [LW+1:0]         sum;
  logic [LW-1:0]         l_nx;

  always_comb begin
    m_s   = m_run;
    m_nx  = (s > m_s) ? s : m_s;
    d_run = {m_s[D_W-1], m_s} - {m_nx[D_W-1], m_nx};
    d_s   = {s[D_W-1], s} - {m_nx[D_W-1], m_nx};
    e_run = exp_q17(d_run);
    e_s   = exp_q17(d_s);
    prod  = (LW+8)'(l_run) * (LW+8)'(e_run);
    sum   = (LW+2)'(prod >> 7) + (LW+2)'({e_s, 1'b0});
    l_nx  = (sum > (LW+2)'({LW{1'b1}})) ? {LW{1'b1}} : sum[LW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= M_MIN; m_old <= M_MIN;
      l_run <= '0;    l_old <= '0;
    end else if (clr) begin
      m_run <= M_MIN; m_old <= M_MIN;
      l_run <= '0;    l_old <= '0;
    end else begin
      if (acc) begin
        m_run <= m_nx;
        l_run <= l_nx;
      end
      if (upd) begin
        m_old <= m_run;
        l_old <= l_run;
      end
    end
  end
endmodule

module row_stat_upd #(
  parameter int D_W = 8,
  parameter int TIL = 16
) (
  input  logic                        I_CLK,
  input  logic                        I_RST_N,
  input  logic                        I_ROW_CLR,
  input  logic                        I_S_VLD,
  input  logic [0:TIL-1][D_W-1:0]     I_S_COL,
  output logic                        O_S_RDY,
  input  logic                        I_UPD_DONE,
  output logic                        O_VLD,
  output logic [0:TIL-1][D_W-1:0]     O_MI_OLD,
  output logic [0:TIL-1][D_W-1:0]     O_MI_NEW,
  output logic [0:TIL-1][2*D_W-1:0]   O_LI_OLD,
  output logic [0:TIL-1][2*D_W-1:0]   O_LI_NEW,
  output logic [7:0]                  O_TILE_CNT
);
  localparam int CW = (TIL > 1) ? $clog2(TIL) : 1;

  typedef enum logic {ACCUM, HOLD} state_t;
  state_t        state;
  logic [CW-1:0] col;
  logic          acc, upd;

  // O_S_RDY / O_VLD are registered copies of the state, so acc/upd are already exclusive.
  assign acc = I_S_VLD && O_S_RDY && !I_ROW_CLR;
  assign upd = I_UPD_DONE && O_VLD && !I_ROW_CLR;

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state <= ACCUM; col <= '0; O_TILE_CNT <= '0;
      O_S_RDY <= 1'b1; O_VLD <= 1'b0;
    end else if (I_ROW_CLR) begin
      state <= ACCUM; col <= '0; O_TILE_CNT <= '0;
      O_S_RDY <= 1'b1; O_VLD <= 1'b0;
    end else begin
      case (state)
        ACCUM: if (acc) begin
          if (col == CW'(TIL-1)) begin
            col <= '0; state <= HOLD;
            O_S_RDY <= 1'b0; O_VLD <= 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        HOLD: if (upd) begin
          O_TILE_CNT <= O_TILE_CNT + 8'd1;
          state <= ACCUM;
          O_S_RDY <= 1'b1; O_VLD <= 1'b0;
        end
        default: state <= ACCUM;
      endcase
    end
  end

  for (genvar i = 0; i < TIL; i++) begin : g_row
    row_stat_lane #(.D_W(D_W)) u_lane (
      .clk   (I_CLK),
      .rst_n (I_RST_N),
      .clr   (I_ROW_CLR),
      .acc   (acc),
      .upd   (upd),
      .s     (I_S_COL[i]),
      .m_run (O_MI_NEW[i]),
      .m_old (O_MI_OLD[i]),
      .l_run (O_LI_NEW[i]),
      .l_old (O_LI_OLD[i])
    );
  end
endmodule

// File: tb/tb_row_stat_upd.sv
// Directed bench for row_stat_upd: tile accumulation, handoff, saturation, stalls, clears, async reset.

module tb_row_stat_upd;
  localparam int D_W = 8;
  localparam int TIL = 16;

  logic                      I_CLK = 1'b0;
  logic                      I_RST_N, I_ROW_CLR, I_S_VLD, I_UPD_DONE;
  logic [0:TIL-1][D_W-1:0]   I_S_COL;
  logic                      O_S_RDY, O_VLD;
  logic [0:TIL-1][D_W-1:0]   O_MI_OLD, O_MI_NEW;
  logic [0:TIL-1][2*D_W-1:0] O_LI_OLD, O_LI_NEW;
  logic [7:0]                O_TILE_CNT;

  row_stat_upd #(.D_W(D_W), .TIL(TIL)) dut (
    .I_CLK(I_CLK), .I_RST_N(I_RST_N), .I_ROW_CLR(I_ROW_CLR),
    .I_S_VLD(I_S_VLD), .I_S_COL(I_S_COL), .O_S_RDY(O_S_RDY),
    .I_UPD_DONE(I_UPD_DONE), .O_VLD(O_VLD),
    .O_MI_OLD(O_MI_OLD), .O_MI_NEW(O_MI_NEW),
    .O_LI_OLD(O_LI_OLD), .O_LI_NEW(O_LI_NEW),
    .O_TILE_CNT(O_TILE_CNT)
  );

  always #5 I_CLK = ~I_CLK;

  int nvec = 0, nerr = 0;
  logic [D_W-1:0]   col_v [TIL];
  logic [D_W-1:0]   e_mn [TIL], e_mo [TIL];
  logic [2*D_W-1:0] e_ln [TIL], e_lo [TIL];
  logic             e_vld, e_rdy;
  logic [7:0]       e_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input logic [D_W-1:0] mn, input logic [2*D_W-1:0] ln,
                         input logic [D_W-1:0] mo, input logic [2*D_W-1:0] lo,
                         input logic vld, input logic [7:0] cnt);
    for (int i = 0; i < TIL; i++) begin
      e_mn[i] = mn; e_ln[i] = ln; e_mo[i] = mo; e_lo[i] = lo;
    end
    e_vld = vld; e_rdy = ~vld; e_cnt = cnt;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_vld"}, 32'(O_VLD), 32'(e_vld));
    chk({tag, "_rdy"}, 32'(O_S_RDY), 32'(e_rdy));
    chk({tag, "_cnt"}, 32'(O_TILE_CNT), 32'(e_cnt));
    for (int i = 0; i < TIL; i++) begin
      chk($sformatf("%s_mn%0d", tag, i), 32'(O_MI_NEW[i]), 32'(e_mn[i]));
      chk($sformatf("%s_ln%0d", tag, i), 32'(O_LI_NEW[i]), 32'(e_ln[i]));
      chk($sformatf("%s_mo%0d", tag, i), 32'(O_MI_OLD[i]), 32'(e_mo[i]));
      chk($sformatf("%s_lo%0d", tag, i), 32'(O_LI_OLD[i]), 32'(e_lo[i]));
    end
  endtask

  task automatic fill(input logic [D_W-1:0] v);
    for (int i = 0; i < TIL; i++) col_v[i] = v;
  endtask

  task automatic tick();
    @(posedge I_CLK); #1;
  endtask

  // One full tile of col_v; with gaps, idle cycles are inserted between some columns.
  task automatic send_tile(input bit gaps);
    for (int c = 0; c < TIL; c++) begin
      if (gaps && (c % 3 == 1)) begin
        I_S_VLD = 1'b0;
        tick(); tick();
      end
      for (int i = 0; i < TIL; i++) I_S_COL[i] = col_v[i];
      I_S_VLD = 1'b1;
      if (c == TIL-1) chk("pre_last_vld", 32'(O_VLD), 32'd0);
      tick();
    end
    I_S_VLD = 1'b0;
    I_S_COL = '0;
  endtask

  task automatic pulse_done();
    I_UPD_DONE = 1'b1; tick(); I_UPD_DONE = 1'b0;
  endtask

  task automatic pulse_clr();
    I_ROW_CLR = 1'b1; tick(); I_ROW_CLR = 1'b0;
  endtask

  initial begin
    int lnew, lold;
    I_RST_N = 1'b0; I_ROW_CLR = 1'b0; I_S_VLD = 1'b0; I_UPD_DONE = 1'b0; I_S_COL = '0;
    tick(); tick();
    set_exp(8'h80, 16'h0, 8'h80, 16'h0, 1'b0, 8'd0);
    chk_all("rst");
    I_RST_N = 1'b1;
    tick();

    // first tile after a clear
    pulse_clr();
    fill(8'h20);
    send_tile(1'b0);
    set_exp(8'h20, 16'h1000, 8'h80, 16'h0, 1'b1, 8'd0);
    chk_all("tile1");

    // S_VLD held high in HOLD must not be accepted
    fill(8'h7f);
    for (int i = 0; i < TIL; i++) I_S_COL[i] = col_v[i];
    I_S_VLD = 1'b1;
    repeat (3) tick();
    I_S_VLD = 1'b0;
    chk_all("hold_svld");

    pulse_done();
    set_exp(8'h20, 16'h1000, 8'h20, 16'h1000, 1'b0, 8'd1);
    chk_all("handoff");

    // UPD_DONE in ACCUM is ignored
    pulse_done();
    tick();
    chk_all("done_accum");

    // second tile with stalls
    fill(8'h20);
    send_tile(1'b1);
    set_exp(8'h20, 16'h2000, 8'h20, 16'h1000, 1'b1, 8'd1);
    chk_all("tile2_gaps");
    pulse_done();

    // saturation over repeated tiles
    for (int k = 3; k <= 17; k++) begin
      send_tile(k[0]);
      lnew = (k * 4096 > 65535) ? 65535 : k * 4096;
      lold = ((k-1) * 4096 > 65535) ? 65535 : (k-1) * 4096;
      set_exp(8'h20, 16'(lnew), 8'h20, 16'(lold), 1'b1, 8'(k-1));
      chk($sformatf("sat_ln_t%0d", k), 32'(O_LI_NEW[0]), 32'(lnew));
      chk($sformatf("sat_lo_t%0d", k), 32'(O_LI_OLD[TIL-1]), 32'(lold));
      if (k >= 16) chk_all($sformatf("sat%0d", k));
      pulse_done();
    end
    chk("cnt17", 32'(O_TILE_CNT), 32'd17);

    // mid-tile clear: 7 columns, then clear with S_VLD also high
    for (int i = 0; i < TIL; i++) I_S_COL[i] = 8'h20;
    I_S_VLD = 1'b1;
    repeat (7) tick();
    for (int i = 0; i < TIL; i++) I_S_COL[i] = 8'h7f;
    I_ROW_CLR = 1'b1;
    tick();
    I_ROW_CLR = 1'b0; I_S_VLD = 1'b0; I_S_COL = '0;
    set_exp(8'h80, 16'h0, 8'h80, 16'h0, 1'b0, 8'd0);
    chk_all("midclr");
    repeat (20) tick();
    chk("midclr_novld", 32'(O_VLD), 32'd0);
    fill(8'h20);
    send_tile(1'b0);
    set_exp(8'h20, 16'h1000, 8'h80, 16'h0, 1'b1, 8'd0);
    chk_all("after_midclr");

    // clear from HOLD, then rows with distinct constant values (incl. the -4.0 boundary)
    pulse_clr();
    chk("clr_hold_vld", 32'(O_VLD), 32'd0);
    for (int i = 0; i < TIL; i++) col_v[i] = 8'(8*i - 64);
    col_v[0] = 8'h80;
    send_tile(1'b0);
    set_exp(8'h00, 16'h1000, 8'h80, 16'h0, 1'b1, 8'd0);
    for (int i = 0; i < TIL; i++) e_mn[i] = col_v[i];
    chk_all("rows");

    // async reset mid-HOLD, between edges
    #2;
    I_RST_N = 1'b0;
    #1;
    set_exp(8'h80, 16'h0, 8'h80, 16'h0, 1'b0, 8'd0);
    chk_all("arst");
    #2;
    I_RST_N = 1'b1;
    fill(8'h20);
    send_tile(1'b0);
    set_exp(8'h20, 16'h1000, 8'h80, 16'h0, 1'b1, 8'd0);
    chk_all("post_arst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/row_stat_upd.md
ROW_STAT_UPD -- requirements
Module: row_stat_upd

Interface
REQ-001 SHALL have parameter D_W, default 8, score/max width; running-sum width is D_W*2.
REQ-002 SHALL have parameter TIL, default 16, rows per tile and columns per tile.
REQ-003 SHALL have port I_CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port I_RST_N, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port I_ROW_CLR, input, 1, starts a new query row block by clearing the statistics.
REQ-006 SHALL have port I_S_VLD, input, 1, score column valid.
REQ-007 SHALL have port I_S_COL [0:TIL-1], input, D_W each, one S-tile column, signed Q2.5, element i belongs to row i.
REQ-008 SHALL have port O_S_RDY, output, 1, column accept ready.
REQ-009 SHALL have port I_UPD_DONE, input, 1, consumer finished with the current statistics (the coefficient unit's valid).
REQ-010 SHALL have port O_VLD, output, 1, the four statistic arrays are valid and stable.
REQ-011 SHALL have ports O_MI_OLD / O_MI_NEW [0:TIL-1], output, D_W each, row max before/after the tile, signed Q2.5.
REQ-012 SHALL have ports O_LI_OLD / O_LI_NEW [0:TIL-1], output, D_W*2 each, row exp-sum before/after the tile, unsigned Q8.8.
REQ-013 SHALL have port O_TILE_CNT, output, 8, tiles completed since the last clear, wrapping 255->0.

Function
REQ-014 SHALL hold per row: running max m_run, running sum l_run, snapshot m_old, l_old; O_MI_NEW=m_run, O_LI_NEW=l_run, O_MI_OLD=m_old, O_LI_OLD=l_old.
REQ-015 SHALL implement states ACCUM and HOLD; O_S_RDY=1 only in ACCUM, O_VLD=1 only in HOLD.
REQ-016 SHALL accept a column when I_S_VLD && O_S_RDY, and SHALL count accepted columns 0..TIL-1 with a column counter.
REQ-017 SHALL update each row i on acceptance, with s=I_S_COL[i]: m'=max(m_run,s); l'=sat16(((l_run*E(m_run-m'))>>7) + (E(s-m')<<1)); m_run<=m', l_run<=l'.
REQ-018 SHALL define E(x) as the 8-bit codebase Exp_x (output unsigned Q1.7, E(0)=0x80), with the 9-bit difference x clamped to 0x80 (-4.0) when below -128.
REQ-019 SHALL compute the product at 24 bits, truncate after the shift, and saturate the sum to 0xFFFF.
REQ-020 SHALL make all TIL row updates in the same cycle, one column per cycle with no bubbles required.
REQ-021 SHALL move from ACCUM to HOLD on the edge accepting column TIL-1, reset the column counter to 0, and raise O_VLD in the next cycle (latency 1 cycle after the last accept).
REQ-022 SHALL, in HOLD, on I_UPD_DONE=1: copy m_old<=m_run and l_old<=l_run, increment O_TILE_CNT, and return to ACCUM.
REQ-023 SHALL ignore I_UPD_DONE in ACCUM and ignore I_S_VLD in HOLD; the outputs SHALL stay constant throughout HOLD.
REQ-024 SHALL, on I_ROW_CLR=1 in any state: m_run=m_old=0x80, l_run=l_old=0, column counter=0, O_TILE_CNT=0, state ACCUM; I_ROW_CLR has priority over a simultaneous accept or I_UPD_DONE.
REQ-025 SHALL make a clear during a partial tile discard the partial columns with no O_VLD pulse.

Reset
REQ-026 SHALL, while I_RST_N=0, asynchronously force: state ACCUM, O_S_RDY=1 once released, O_VLD=0, all m=0x80, all l=0x0000, counters 0.
REQ-027 SHALL take reset deassertion synchronously to I_CLK; the first column can be accepted on the first edge after release.

Verification
REQ-028 SHALL cover first tile: clear, then 16 columns all 0x20 back-to-back -> O_VLD one cycle after the 16th accept; MI_NEW=0x20, LI_NEW=0x1000, MI_OLD=0x80, LI_OLD=0; O_S_RDY=0.
REQ-029 SHALL cover the handoff: after REQ-028, pulse I_UPD_DONE -> next cycle O_VLD=0, O_S_RDY=1, MI_OLD=0x20, LI_OLD=0x1000, O_TILE_CNT=1; a second all-0x20 tile -> LI_NEW=0x2000.
REQ-030 SHALL cover saturation: repeat all-0x20 tiles with I_UPD_DONE between them -> LI_NEW reaches 0xFFFF on the 16th tile, stays 0xFFFF, never wraps.
REQ-031 SHALL cover stalls and illegal inputs: I_S_VLD toggled with gaps -> results identical to the back-to-back case; I_S_VLD held in HOLD -> no accept; I_UPD_DONE in ACCUM -> no effect.
REQ-032 SHALL cover mid-tile clear: clear after 7 columns, with I_S_VLD also high in that cycle -> that column is not applied; all stats 0x80/0; the next full tile matches REQ-028 exactly.
REQ-033 SHALL cover async reset: assert I_RST_N=0 mid-HOLD between clock edges -> O_VLD falls immediately; all outputs return to their reset values.
